// File: rtl/full_adder_16.sv
// 16-bit ripple-carry adder with carry-in, carry-out and signed overflow,
// registered at the output. Built from 1-bit full-adder cells grouped into
// 4-bit slices, two 4-bit slices per 8-bit slice, two 8-bit slices per word.
//
// Build option: define FULL_ADDER_16_PIPE_EN to insert a pipeline register
// between the two 8-bit slices (2-cycle latency, same throughput). Without it
// the adder has 1-cycle latency.

// 1-bit full-adder cell.
module full_adder_16_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    logic w_p;

    // Propagate term shared by the sum and carry equations.
    assign w_p    = i_a ^ i_b;
    assign o_sum  = w_p ^ i_cin;
    assign o_cout = (i_a & i_b) | (w_p & i_cin);

endmodule

// 4-bit ripple slice. Also exposes the carry into its MSB cell so the top
// slice of the word can form the signed-overflow flag.
module full_adder_16_add4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout,
    output logic       o_cmsb
);

    // w_c[k] is the carry into bit k; w_c[4] is the carry out of the slice.
    logic [4:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar gi = 0; gi < 4; gi++) begin : g_cell
        full_adder_16_fa u_fa (
            .i_a    (i_a[gi]),
            .i_b    (i_b[gi]),
            .i_cin  (w_c[gi]),
            .o_sum  (o_sum[gi]),
            .o_cout (w_c[gi+1])
        );
    end

    assign o_cout = w_c[4];
    assign o_cmsb = w_c[3];

endmodule

// 8-bit ripple slice: low nibble carry feeds the high nibble.
module full_adder_16_add8 (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout,
    output logic       o_cmsb
);

    logic w_c4;
    logic w_unused_cmsb_lo;

    full_adder_16_add4 u_lo (
        .i_a    (i_a[3:0]),
        .i_b    (i_b[3:0]),
        .i_cin  (i_cin),
        .o_sum  (o_sum[3:0]),
        .o_cout (w_c4),
        .o_cmsb (w_unused_cmsb_lo)
    );

    full_adder_16_add4 u_hi (
        .i_a    (i_a[7:4]),
        .i_b    (i_b[7:4]),
        .i_cin  (w_c4),
        .o_sum  (o_sum[7:4]),
        .o_cout (o_cout),
        .o_cmsb (o_cmsb)
    );

endmodule

// Top level: two 8-bit slices plus output (and optional mid-chain) registers.
module full_adder_16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic        out_valid,
    output logic [15:0] sum,
    output logic        ca,
    output logic        ovf
);

    logic [7:0]  w_sum_lo;
    logic [7:0]  w_sum_hi;
    logic        w_c8;
    logic        w_c15;
    logic        w_c16;
    logic        w_unused_c7;

    logic        r_out_valid;
    logic [15:0] r_sum;
    logic        r_ca;
    logic        r_ovf;

    // Low byte always works directly on the input operands.
    full_adder_16_add8 u_lo (
        .i_a    (a[7:0]),
        .i_b    (b[7:0]),
        .i_cin  (cin),
        .o_sum  (w_sum_lo),
        .o_cout (w_c8),
        .o_cmsb (w_unused_c7)
    );

`ifdef FULL_ADDER_16_PIPE_EN

    logic        r_s1_valid;
    logic [7:0]  r_s1_sum_lo;
    logic        r_s1_c8;
    logic [7:0]  r_s1_a_hi;
    logic [7:0]  r_s1_b_hi;

    // High byte consumes the operands and carry captured by stage 1.
    full_adder_16_add8 u_hi (
        .i_a    (r_s1_a_hi),
        .i_b    (r_s1_b_hi),
        .i_cin  (r_s1_c8),
        .o_sum  (w_sum_hi),
        .o_cout (w_c16),
        .o_cmsb (w_c15)
    );

    // Stage 1: capture low-byte result, mid-chain carry and upper operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_sum_lo <= 8'h00;
            r_s1_c8     <= 1'b0;
            r_s1_a_hi   <= 8'h00;
            r_s1_b_hi   <= 8'h00;
        end else begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sum_lo <= w_sum_lo;
                r_s1_c8     <= w_c8;
                r_s1_a_hi   <= a[15:8];
                r_s1_b_hi   <= b[15:8];
            end
        end
    end

    // Stage 2: finish the high byte and register the full result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= 16'h0000;
            r_ca        <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sum <= {w_sum_hi, r_s1_sum_lo};
                r_ca  <= w_c16;
                r_ovf <= w_c15 ^ w_c16;
            end
        end
    end

`else

    // High byte chained directly off the low byte carry.
    full_adder_16_add8 u_hi (
        .i_a    (a[15:8]),
        .i_b    (b[15:8]),
        .i_cin  (w_c8),
        .o_sum  (w_sum_hi),
        .o_cout (w_c16),
        .o_cmsb (w_c15)
    );

    // Single output stage; data holds when no new operands arrive.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= 16'h0000;
            r_ca        <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_sum <= {w_sum_hi, w_sum_lo};
                r_ca  <= w_c16;
                r_ovf <= w_c15 ^ w_c16;
            end
        end
    end

`endif

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign ca        = r_ca;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_full_adder_16.sv
// Self-checking bench for full_adder_16: directed vector table, reset checks,
// random streaming against a 17-bit golden sum, and reset during streaming.
module tb_full_adder_16;

`ifdef FULL_ADDER_16_PIPE_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif
    localparam int NSTREAM = 1000;
    localparam int NMID    = 10;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic [15:0] sum;
    logic        ca;
    logic        ovf;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        ca;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    logic [15:0] exp_sum[NSTREAM];
    logic        exp_ca[NSTREAM];
    logic        exp_ovf[NSTREAM];

    full_adder_16 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum),
        .ca        (ca),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic v, input logic [15:0] s,
                              input logic c, input logic o);
        check({name, ".valid"}, 32'(out_valid), 32'(v));
        check({name, ".sum"},   32'(sum),       32'(s));
        check({name, ".ca"},    32'(ca),        32'(c));
        check({name, ".ovf"},   32'(ovf),       32'(o));
    endtask

    initial begin
        logic [16:0] full;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic        ev;

        n_checks = 0;
        n_errors = 0;

        //              a        b        cin   sum      ca    ovf
        vecs[0]  = '{16'hAAAA, 16'hAAAA, 1'b0, 16'h5554, 1'b1, 1'b1};
        vecs[1]  = '{16'hAAAA, 16'hAAAA, 1'b1, 16'h5555, 1'b1, 1'b1};
        vecs[2]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[3]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[4]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[5]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[8]  = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[9]  = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[10] = '{16'hFFFE, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[11] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};

        // Reset held for two cycles while inputs claim to be valid.
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 16'h1234;
        b        = 16'h0000;
        cin      = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_outs("rst_hold", 1'b0, 16'h0000, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < L; i++) begin
            @(posedge clk);
            #1;
            check_outs("rst_release", 1'b0, 16'h0000, 1'b0, 1'b0);
        end

        // Directed vectors, one at a time.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a        = vecs[i].a;
            b        = vecs[i].b;
            cin      = vecs[i].cin;
            repeat (L) @(posedge clk);
            #1;
            check_outs($sformatf("vec%0d", i), 1'b1, vecs[i].sum, vecs[i].ca, vecs[i].ovf);
            @(negedge clk);
            in_valid = 1'b0;
        end

        // Back-to-back random stream against a 17-bit golden sum.
        for (int i = 0; i < NSTREAM + L - 1; i++) begin
            @(negedge clk);
            if (i < NSTREAM) begin
                ra   = 16'($urandom);
                rb   = 16'($urandom);
                rc   = 1'($urandom_range(0, 1));
                full = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
                exp_sum[i] = full[15:0];
                exp_ca[i]  = full[16];
                exp_ovf[i] = (ra[15] == rb[15]) && (full[15] != ra[15]);
                in_valid = 1'b1;
                a        = ra;
                b        = rb;
                cin      = rc;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (i >= L - 1) begin
                check_outs($sformatf("stream%0d", i - L + 1), 1'b1, exp_sum[i - L + 1],
                           exp_ca[i - L + 1], exp_ovf[i - L + 1]);
            end
        end

        // Drop in_valid: valid falls, data holds the last result.
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_outs("hold", 1'b0, exp_sum[NSTREAM-1], exp_ca[NSTREAM-1],
                       exp_ovf[NSTREAM-1]);
        end

        // Reset during streaming: pre-reset sums are < 0x8000, post-reset >= 0x8000.
        for (int i = 0; i < NMID; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a        = 16'(i + 1);
            b        = 16'h0000;
            cin      = 1'b0;
        end
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 16'h0077;
        @(posedge clk);
        #1;
        check("mid_rst.valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < NMID + L; j++) begin
            if (j < NMID) begin
                in_valid = 1'b1;
                a        = 16'(16'h8000 + j);
                b        = 16'h0000;
                cin      = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            ev = (j >= L - 1) && (j - L + 1 < NMID);
            check($sformatf("post_rst%0d.valid", j), 32'(out_valid), 32'(ev));
            if (ev) begin
                check($sformatf("post_rst%0d.sum", j), 32'(sum), 32'(16'h8000 + j - L + 1));
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
